hw_sched_voter: RTL
===================

// Module: hw_sched_voter
// PURPOSE
//  Parametrised successor to the OOO/pipelined-core swap scheduler. Counts NUM_EVENTS
//  event classes on both cores, plus OOO ROB-full cycles, over a fixed window.
//  At each window end it forms a majority vote to migrate the thread. On a pass it
//  requests a drain, issues a one-cycle swap_pc once both cores are empty, then holds off
//  further swaps for a cooldown. Adds drain timeout/abort, force/disable controls and status.
// PARAMETERS
//  NUM_EVENTS       5      event classes per core (bit i of ooo_/ppl_event_en)
//  CMP_DIR          5'b00110 per-class vote sense: 1 = vote if ooo>ppl, 0 = vote if ooo<ppl
//  WINDOW_LEN       10000  cycles per sampling window (>=2)
//  CNT_W            16     event counter width, saturating
//  ROB_THRESHOLD    6666   ROB-full count strictly above which the ROB votes
//  VOTE_THRESHOLD   3      votes (of NUM_EVENTS+1) needed to trigger
//  DRAIN_TIMEOUT    1024   max cycles in DRAIN before abort (>=1)
//  COOLDOWN_WINDOWS 2      window ends ignored after swap/abort (0 allowed)
// PORTS
//  clk                      in  1                clock
//  rst                      in  1                reset
//  ooo_event_en             in  NUM_EVENTS       OOO per-class event strobes
//  ppl_event_en             in  NUM_EVENTS       pipelined-core per-class event strobes
//  ooo_rob_full             in  1                OOO ROB full this cycle
//  rob_empty                in  1                OOO ROB empty
//  pipeline_registers_empty in  1                pipelined core drained
//  force_swap               in  1                debug: request swap now
//  sched_disable            in  1                inhibit triggers; aborts DRAIN
//  drain_req                out 1                asserted throughout DRAIN
//  swap_pc                  out 1                1-cycle swap pulse
//  swap_abort               out 1                1-cycle pulse on DRAIN timeout/disable
//  window_end               out 1                1-cycle pulse, last cycle of window
//  last_votes               out $clog2(NUM_EVENTS+2)  votes latched at last window end
//  swap_count               out 16               completed swaps, saturating
//  state                    out 2                0 IDLE, 1 DRAIN, 2 SWAP, 3 COOLDOWN
// BEHAVIOUR
//  Reset: rst is synchronous and active-high; the clock is clk. Reset zeroes all counters,
//   the sync flops, last_votes and swap_count; state=IDLE; all pulse outputs are 0.
//  Window: win_cnt counts 0..WINDOW_LEN-1 and wraps. window_end=(win_cnt==WINDOW_LEN-1).
//   The window runs in every state.
//  Counters: each strobe increments its counter by 1 and saturates at 2^CNT_W-1. On the
//   window_end cycle, every counter clears to 0 and strobes in that cycle are dropped.
//  Vote: evaluated on the pre-clear counter values at window_end. Class i votes by CMP_DIR[i];
//   equal counts do not vote. The ROB votes when rob_cnt>ROB_THRESHOLD. last_votes
//   takes the popcount at window_end.
//  Sync: rob_empty passes through 2 flops and pipeline_registers_empty through 1; the
//   drain condition is both delayed values high in the same cycle.
//  FSM:
//   IDLE: -> DRAIN when (window_end & votes>=VOTE_THRESHOLD & !sched_disable) or
//    (force_swap & !sched_disable). sched_disable has priority.
//   DRAIN: drain_req=1. If sched_disable, -> COOLDOWN with a swap_abort pulse. Else if the
//    drain condition holds, -> SWAP. Else if DRAIN_TIMEOUT cycles have elapsed in DRAIN,
//    -> COOLDOWN with a swap_abort pulse. Disable outranks drain, which outranks timeout.
//   SWAP: 1 cycle, swap_pc=1, drain_req=0; swap_count+1 (saturating at 16'hFFFF)
//    -> COOLDOWN.
//   COOLDOWN: cd_cnt loads COOLDOWN_WINDOWS on entry and decrements on each window_end;
//    votes and force_swap are ignored. -> IDLE when cd_cnt==0. With COOLDOWN_WINDOWS=0,
//    COOLDOWN lasts exactly 1 cycle.
//  Latency: earliest swap_pc is 3 cycles after entering DRAIN when rob_empty and
//   pipeline_registers_empty are already high (2-flop sync).
//  drain_req, swap_pc and swap_abort are registered (state-decoded), glitch-free.
// TESTING
//  (WINDOW_LEN=16, DRAIN_TIMEOUT=8, COOLDOWN_WINDOWS=1, default CMP_DIR/VOTE_THRESHOLD)
//  1 Reset mid-DRAIN: assert rst -> next cycle state=0, drain_req=0, swap_count=0,
//    last_votes=0.
//  2 ooo_event_en[1]/[2] strobed 5x, ppl 2x; ooo[0] 1x, ppl[0] 4x -> window_end:
//    last_votes=3, DRAIN entered; both empties high -> swap_pc 3 cycles later,
//    swap_count=1.
//  3 Equal counts on all classes, rob_cnt=ROB_THRESHOLD -> last_votes=0, state stays IDLE.
//  4 Enter DRAIN, rob_empty held 0 -> swap_abort after 8 DRAIN cycles, COOLDOWN,
//    swap_count unchanged.
//  5 Trigger during COOLDOWN -> ignored until the next window_end, then IDLE; the next
//    qualifying window -> DRAIN.
//  6 force_swap with sched_disable=1 -> no DRAIN. sched_disable raised in DRAIN ->
//    swap_abort pulse, drain_req low next cycle.

Source files
------------

// File: rtl/hw_sched_voter.sv
// Window-based majority-vote scheduler for migrating a thread between an OOO core and a
// pipelined core: counts events per window, votes, drains both cores, pulses swap_pc.
module hw_sched_voter #(
  parameter int                    NUM_EVENTS       = 5,
  parameter logic [NUM_EVENTS-1:0] CMP_DIR          = 5'b00110,
  parameter int                    WINDOW_LEN       = 10000,
  parameter int                    CNT_W            = 16,
  parameter int                    ROB_THRESHOLD    = 6666,
  parameter int                    VOTE_THRESHOLD   = 3,
  parameter int                    DRAIN_TIMEOUT    = 1024,
  parameter int                    COOLDOWN_WINDOWS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_EVENTS-1:0]             ooo_event_en,
  input  logic [NUM_EVENTS-1:0]             ppl_event_en,
  input  logic                              ooo_rob_full,
  input  logic                              rob_empty,
  input  logic                              pipeline_registers_empty,
  input  logic                              force_swap,
  input  logic                              sched_disable,
  output logic                              drain_req,
  output logic                              swap_pc,
  output logic                              swap_abort,
  output logic                              window_end,
  output logic [$clog2(NUM_EVENTS+2)-1:0]   last_votes,
  output logic [15:0]                       swap_count,
  output logic [1:0]                        state
);

  localparam int VOTE_W = $clog2(NUM_EVENTS + 2);
  localparam int WIN_W  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int TO_W   = $clog2(DRAIN_TIMEOUT + 1);
  localparam int CD_W   = $clog2(COOLDOWN_WINDOWS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    SWAP     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t            cur, nxt;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  ooo_cnt [NUM_EVENTS];
  logic [CNT_W-1:0]  ppl_cnt [NUM_EVENTS];
  logic [CNT_W-1:0]  rob_cnt;
  logic [VOTE_W-1:0] votes;
  logic              rob_s1, rob_s2, ppl_s1;
  logic              drain_ok;
  logic [TO_W-1:0]   drain_cnt;
  logic              timeout;
  logic [CD_W-1:0]   cd_cnt;
  logic              abort;

  assign window_end = (win_cnt == WIN_W'(WINDOW_LEN - 1));
  assign state      = cur;

  always_ff @(posedge clk) begin
    if (rst || window_end) win_cnt <= '0;
    else                   win_cnt <= win_cnt + WIN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        ooo_cnt[i] <= '0;
        ppl_cnt[i] <= '0;
      end
      rob_cnt    <= '0;
      last_votes <= '0;
    end else if (window_end) begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        ooo_cnt[i] <= '0;
        ppl_cnt[i] <= '0;
      end
      rob_cnt    <= '0;
      last_votes <= votes;
    end else begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        if (ooo_event_en[i] && ooo_cnt[i] != CNT_MAX) ooo_cnt[i] <= ooo_cnt[i] + CNT_W'(1);
        if (ppl_event_en[i] && ppl_cnt[i] != CNT_MAX) ppl_cnt[i] <= ppl_cnt[i] + CNT_W'(1);
      end
      if (ooo_rob_full && rob_cnt != CNT_MAX) rob_cnt <= rob_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    votes = '0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (CMP_DIR[i] ? (ooo_cnt[i] > ppl_cnt[i]) : (ooo_cnt[i] < ppl_cnt[i]))
        votes = votes + VOTE_W'(1);
    end
    if (rob_cnt > CNT_W'(ROB_THRESHOLD)) votes = votes + VOTE_W'(1);
  end

  // Sync flops only run inside DRAIN so emptiness is always re-observed after the drain
  // request; this gives the fixed 3-cycle minimum from DRAIN entry to swap_pc.
  always_ff @(posedge clk) begin
    if (rst || cur != DRAIN) begin
      rob_s1 <= 1'b0;
      rob_s2 <= 1'b0;
      ppl_s1 <= 1'b0;
    end else begin
      rob_s1 <= rob_empty;
      rob_s2 <= rob_s1;
      ppl_s1 <= pipeline_registers_empty;
    end
  end

  assign drain_ok = rob_s2 && ppl_s1;
  assign timeout  = (drain_cnt == TO_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || cur != DRAIN) drain_cnt <= '0;
    else if (!timeout)       drain_cnt <= drain_cnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt   = cur;
    abort = 1'b0;
    unique case (cur)
      IDLE: begin
        if (!sched_disable && (force_swap || (window_end && votes >= VOTE_W'(VOTE_THRESHOLD))))
          nxt = DRAIN;
      end
      DRAIN: begin
        if (sched_disable) begin
          nxt   = COOLDOWN;
          abort = 1'b1;
        end else if (drain_ok) begin
          nxt = SWAP;
        end else if (timeout) begin
          nxt   = COOLDOWN;
          abort = 1'b1;
        end
      end
      SWAP:     nxt = COOLDOWN;
      COOLDOWN: if (cd_cnt == '0) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cd_cnt <= '0;
    end else if (cur != COOLDOWN && nxt == COOLDOWN) begin
      cd_cnt <= CD_W'(COOLDOWN_WINDOWS);
    end else if (cur == COOLDOWN && window_end && cd_cnt != '0) begin
      cd_cnt <= cd_cnt - CD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_req  <= 1'b0;
      swap_pc    <= 1'b0;
      swap_abort <= 1'b0;
      swap_count <= '0;
    end else begin
      drain_req  <= (nxt == DRAIN);
      swap_pc    <= (nxt == SWAP);
      swap_abort <= abort;
      if (cur == SWAP && swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
    end
  end

endmodule
